// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler
//   Shares one external ALU (ADD=00, MUL=01, OR=10, AND=11) between NREQ requesters.
//   Round-robin pick among the requests seen in IDLE. The winner's operands go out on
//   registered alu_* ports. The ALU result and flags are captured one cycle later and
//   returned over a per-requester valid/ready response channel. One op in flight.
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   req/req_opcode/req_a/req_b    per-requester request and packed operands
//   gnt                           one-hot, single-cycle accept pulse
//   alu_opcode/operand1/operand2  registered drive to the ALU
//   alu_result/cflag/zflag        combinational ALU response
//   rsp_valid/rsp_ready           one-hot response handshake
//   rsp_result/cflag/zflag/id     captured response payload
//   busy                          op in ISSUE or RESP
//   op_count                      completed-op counter, wraps
module alu_rr_scheduler #(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned IDW     = 1,
  parameter int unsigned OPW     = 4,
  parameter int unsigned RESW    = 8,
  parameter int unsigned COUNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [2*NREQ-1:0]   req_opcode,
  input  logic [OPW*NREQ-1:0] req_a,
  input  logic [OPW*NREQ-1:0] req_b,
  output logic [NREQ-1:0]     gnt,
  output logic [1:0]          alu_opcode,
  output logic [OPW-1:0]      alu_operand1,
  output logic [OPW-1:0]      alu_operand2,
  input  logic [RESW-1:0]     alu_result,
  input  logic                alu_cflag,
  input  logic                alu_zflag,
  output logic [NREQ-1:0]     rsp_valid,
  input  logic [NREQ-1:0]     rsp_ready,
  output logic [RESW-1:0]     rsp_result,
  output logic                rsp_cflag,
  output logic                rsp_zflag,
  output logic [IDW-1:0]      rsp_id,
  output logic                busy,
  output logic [COUNT_W-1:0]  op_count
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e              state_q, state_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [1:0]          alu_opcode_q, alu_opcode_d;
  logic [OPW-1:0]      alu_op1_q, alu_op1_d;
  logic [OPW-1:0]      alu_op2_q, alu_op2_d;
  logic [NREQ-1:0]     rsp_valid_q, rsp_valid_d;
  logic [RESW-1:0]     rsp_result_q, rsp_result_d;
  logic                rsp_cflag_q, rsp_cflag_d;
  logic                rsp_zflag_q, rsp_zflag_d;
  logic [IDW-1:0]      rsp_id_q, rsp_id_d;
  logic                busy_q, busy_d;
  logic [COUNT_W-1:0]  op_count_q, op_count_d;
  logic [IDW-1:0]      last_q, last_d;

  // Round-robin pick: scan indices last+1, last+2, ... wrapping; first asserted wins.
  logic                win_found;
  logic [IDW-1:0]      win_idx;
  logic [IDW-1:0]      cand;
  int unsigned         win_w;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IDW'((32'(last_q) + k) % NREQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    win_w = 32'(win_idx);
  end

  always_comb begin
    state_d      = state_q;
    gnt_d        = '0;
    alu_opcode_d = alu_opcode_q;
    alu_op1_d    = alu_op1_q;
    alu_op2_d    = alu_op2_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_cflag_d  = rsp_cflag_q;
    rsp_zflag_d  = rsp_zflag_q;
    rsp_id_d     = rsp_id_q;
    op_count_d   = op_count_q;
    last_d       = last_q;

    case (state_q)
      StIdle: begin
        if (win_found) begin
          alu_opcode_d   = req_opcode[2*win_w +: 2];
          alu_op1_d      = req_a[OPW*win_w +: OPW];
          alu_op2_d      = req_b[OPW*win_w +: OPW];
          gnt_d[win_idx] = 1'b1;
          rsp_id_d       = win_idx;
          last_d         = win_idx;
          state_d        = StIssue;
        end
      end
      StIssue: begin
        // alu_* have been stable for this whole cycle, so the ALU output is settled.
        rsp_result_d          = alu_result;
        rsp_cflag_d           = alu_cflag;
        rsp_zflag_d           = alu_zflag;
        rsp_valid_d           = '0;
        rsp_valid_d[rsp_id_q] = 1'b1;
        state_d               = StResp;
      end
      StResp: begin
        if (rsp_ready[rsp_id_q]) begin
          rsp_valid_d = '0;
          op_count_d  = op_count_q + COUNT_W'(1);
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      gnt_q        <= '0;
      alu_opcode_q <= '0;
      alu_op1_q    <= '0;
      alu_op2_q    <= '0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_cflag_q  <= 1'b0;
      rsp_zflag_q  <= 1'b0;
      rsp_id_q     <= '0;
      busy_q       <= 1'b0;
      op_count_q   <= '0;
      // Start at the top index so requester 0 has first priority.
      last_q       <= IDW'(NREQ - 1);
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      alu_opcode_q <= alu_opcode_d;
      alu_op1_q    <= alu_op1_d;
      alu_op2_q    <= alu_op2_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_cflag_q  <= rsp_cflag_d;
      rsp_zflag_q  <= rsp_zflag_d;
      rsp_id_q     <= rsp_id_d;
      busy_q       <= busy_d;
      op_count_q   <= op_count_d;
      last_q       <= last_d;
    end
  end

  assign gnt          = gnt_q;
  assign alu_opcode   = alu_opcode_q;
  assign alu_operand1 = alu_op1_q;
  assign alu_operand2 = alu_op2_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_cflag    = rsp_cflag_q;
  assign rsp_zflag    = rsp_zflag_q;
  assign rsp_id       = rsp_id_q;
  assign busy         = busy_q;
  assign op_count     = op_count_q;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Bench for alu_rr_scheduler: NREQ=2, COUNT_W=2 so counter wrap is reachable.
// A behavioural ALU sits on the alu_* ports; a transaction-level model predicts every
// output each cycle, and directed sequences add hand-computed literal checks.
module tb_alu_rr_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [3:0] req_opcode;
  logic [7:0] req_a, req_b;
  logic [1:0] gnt;
  logic [1:0] alu_opcode;
  logic [3:0] alu_operand1, alu_operand2;
  logic [7:0] alu_result;
  logic       alu_cflag, alu_zflag;
  logic [1:0] rsp_valid, rsp_ready;
  logic [7:0] rsp_result;
  logic       rsp_cflag, rsp_zflag;
  logic [0:0] rsp_id;
  logic       busy;
  logic [1:0] op_count;

  int tests = 0;
  int fails = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  alu_rr_scheduler #(
    .NREQ(2), .IDW(1), .OPW(4), .RESW(8), .COUNT_W(2)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_opcode(req_opcode), .req_a(req_a),
    .req_b(req_b), .gnt(gnt), .alu_opcode(alu_opcode), .alu_operand1(alu_operand1),
    .alu_operand2(alu_operand2), .alu_result(alu_result), .alu_cflag(alu_cflag),
    .alu_zflag(alu_zflag), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_cflag(rsp_cflag), .rsp_zflag(rsp_zflag),
    .rsp_id(rsp_id), .busy(busy), .op_count(op_count)
  );

  // ALU: {carry, zero, result}. Carry is the bit-4 carry out of ADD only.
  function automatic logic [9:0] alu_f(input logic [1:0] op, input logic [3:0] a,
                                       input logic [3:0] b);
    logic [7:0] r;
    logic       c;
    c = 1'b0;
    case (op)
      2'd0: begin r = {4'b0, a} + {4'b0, b}; c = r[4]; end
      2'd1: r = {4'b0, a} * {4'b0, b};
      2'd2: r = {4'b0, a | b};
      default: r = {4'b0, a & b};
    endcase
    return {c, (r == 8'd0), r};
  endfunction

  assign {alu_cflag, alu_zflag, alu_result} = alu_f(alu_opcode, alu_operand1, alu_operand2);

  // Model: m_ph counts the phase of the single in-flight op (0 none, 1 accepted, 2 answering).
  function automatic int pick(input logic [1:0] r, input int last);
    for (int k = 1; k <= 2; k++) begin
      if (r[(last + k) % 2]) return (last + k) % 2;
    end
    return 0;
  endfunction

  int         m_ph, m_last, m_id, w_pick;
  logic [1:0] m_gnt, m_rv, m_op, m_cnt;
  logic [3:0] m_a, m_b;
  logic [7:0] m_res;
  logic       m_c, m_z;

  always_comb w_pick = pick(req, m_last);

  always @(posedge clk) begin
    if (rst) begin
      m_ph <= 0; m_last <= 1; m_id <= 0; m_gnt <= 2'b0; m_rv <= 2'b0; m_op <= 2'b0;
      m_a <= 4'b0; m_b <= 4'b0; m_res <= 8'b0; m_c <= 1'b0; m_z <= 1'b0; m_cnt <= 2'b0;
    end else begin
      case (m_ph)
        0: if (req != 2'b0) begin
          m_op   <= req_opcode[2*w_pick +: 2];
          m_a    <= req_a[4*w_pick +: 4];
          m_b    <= req_b[4*w_pick +: 4];
          m_gnt  <= 2'b01 << w_pick;
          m_id   <= w_pick;
          m_last <= w_pick;
          m_ph   <= 1;
        end
        1: begin
          {m_c, m_z, m_res} <= alu_f(m_op, m_a, m_b);
          m_rv  <= 2'b01 << m_id;
          m_gnt <= 2'b0;
          m_ph  <= 2;
        end
        default: if (rsp_ready[m_id]) begin
          m_rv  <= 2'b0;
          m_cnt <= m_cnt + 2'd1;
          m_ph  <= 0;
        end
      endcase
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("gnt", 32'(gnt), 32'(m_gnt));
      check("rsp_valid", 32'(rsp_valid), 32'(m_rv));
      check("alu_opcode", 32'(alu_opcode), 32'(m_op));
      check("alu_operand1", 32'(alu_operand1), 32'(m_a));
      check("alu_operand2", 32'(alu_operand2), 32'(m_b));
      check("rsp_result", 32'(rsp_result), 32'(m_res));
      check("rsp_cflag", 32'(rsp_cflag), 32'(m_c));
      check("rsp_zflag", 32'(rsp_zflag), 32'(m_z));
      check("rsp_id", 32'(rsp_id), 32'(m_id[0]));
      check("busy", 32'(busy), 32'(m_ph != 0));
      check("op_count", 32'(op_count), 32'(m_cnt));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [3:0] a,
                         input logic [3:0] b);
    req_opcode[2*i +: 2] = op;
    req_a[4*i +: 4]      = a;
    req_b[4*i +: 4]      = b;
    req[i]               = 1'b1;
  endtask

  task automatic wait_gnt(input int i);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      cyc(1);
      seen = gnt[i];
    end
    check("wait_gnt", 32'(seen), 32'd1);
  endtask

  task automatic do_op(input int i, input logic [1:0] op, input logic [3:0] a,
                       input logic [3:0] b, input logic [7:0] res, input logic c,
                       input logic z);
    set_req(i, op, a, b);
    wait_gnt(i);
    req[i] = 1'b0;
    cyc(1);
    check("op rsp_valid", 32'(rsp_valid), 32'(2'b01 << i));
    check("op result", 32'(rsp_result), 32'(res));
    check("op cflag", 32'(rsp_cflag), 32'(c));
    check("op zflag", 32'(rsp_zflag), 32'(z));
    check("op id", 32'(rsp_id), i);
    cyc(1);
  endtask

  initial begin
    rst = 1'b1; req = 2'b0; req_opcode = '0; req_a = '0; req_b = '0; rsp_ready = 2'b11;
    cyc(2);
    chk_en = 1'b1;
    check("reset gnt", 32'(gnt), 0);
    check("reset rsp_valid", 32'(rsp_valid), 0);
    check("reset busy", 32'(busy), 0);
    check("reset op_count", 32'(op_count), 0);
    rst = 1'b0;

    // 1: single ADD 4,5
    set_req(0, 2'd0, 4'd4, 4'd5);
    cyc(1);
    check("t1 gnt", 32'(gnt), 32'd1);
    check("t1 busy", 32'(busy), 32'd1);
    req[0] = 1'b0;
    cyc(1);
    check("t1 rsp_valid", 32'(rsp_valid), 32'd1);
    check("t1 result", 32'(rsp_result), 32'd9);
    check("t1 c/z/id", {rsp_cflag, rsp_zflag, rsp_id}, 32'd0);
    cyc(1);
    check("t1 op_count", 32'(op_count), 32'd1);

    // 2: simultaneous requests after reset, round robin
    rst = 1'b1; cyc(1); rst = 1'b0;
    set_req(0, 2'd0, 4'd12, 4'd5);
    set_req(1, 2'd1, 4'd15, 4'd15);
    cyc(1);
    check("t2 first gnt", 32'(gnt), 32'd1);
    req[0] = 1'b0;
    cyc(1);
    check("t2 add result", 32'(rsp_result), 32'd17);
    check("t2 add carry", 32'(rsp_cflag), 32'd1);
    cyc(2);
    check("t2 second gnt", 32'(gnt), 32'd2);
    req[1] = 1'b0;
    cyc(1);
    check("t2 mul result", 32'(rsp_result), 32'd225);
    check("t2 mul c/id", {rsp_cflag, rsp_id}, 32'd1);
    cyc(1);
    set_req(0, 2'd2, 4'd1, 4'd8);
    set_req(1, 2'd3, 4'd7, 4'd3);
    cyc(1);
    check("t2 rr again gnt", 32'(gnt), 32'd1);
    req[0] = 1'b0;
    wait_gnt(1);
    req[1] = 1'b0;
    cyc(2);

    // 3: response back-pressure with requester 1 waiting
    rsp_ready = 2'b10;
    set_req(0, 2'd0, 4'd3, 4'd3);
    wait_gnt(0);
    req[0] = 1'b0;
    set_req(1, 2'd2, 4'd1, 4'd2);
    cyc(1);
    check("t3 rsp_valid", 32'(rsp_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      check("t3 hold result", 32'(rsp_result), 32'd6);
      check("t3 hold valid", 32'(rsp_valid), 32'd1);
      check("t3 hold busy", 32'(busy), 32'd1);
      check("t3 no gnt", 32'(gnt), 32'd0);
    end
    rsp_ready = 2'b11;
    cyc(1);
    check("t3 after hs valid", 32'(rsp_valid), 32'd0);
    check("t3 after hs gnt", 32'(gnt), 32'd0);
    cyc(1);
    check("t3 gnt1", 32'(gnt), 32'd2);
    req[1] = 1'b0;
    cyc(1);
    check("t3 or result", 32'(rsp_result), 32'd3);
    cyc(1);

    // 4: zero flag
    do_op(0, 2'd3, 4'd2, 4'd4, 8'd0, 1'b0, 1'b1);
    do_op(1, 2'd2, 4'd2, 4'd4, 8'd6, 1'b0, 1'b0);

    // 5: reset during ISSUE
    set_req(0, 2'd0, 4'd1, 4'd1);
    cyc(1);
    check("t5 gnt before rst", 32'(gnt), 32'd1);
    req[0] = 1'b0;
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("t5 gnt", 32'(gnt), 32'd0);
    check("t5 rsp_valid", 32'(rsp_valid), 32'd0);
    check("t5 op_count", 32'(op_count), 32'd0);
    cyc(1);
    check("t5 no late rsp", 32'(rsp_valid), 32'd0);
    do_op(0, 2'd0, 4'd7, 4'd8, 8'd15, 1'b0, 1'b0);

    // 6: counter wrap and withdrawn request
    do_op(1, 2'd3, 4'd15, 4'd15, 8'd15, 1'b0, 1'b0);
    do_op(0, 2'd1, 4'd0, 4'd9, 8'd0, 1'b0, 1'b1);
    do_op(1, 2'd0, 4'd15, 4'd1, 8'd16, 1'b1, 1'b0);
    do_op(0, 2'd2, 4'd0, 4'd0, 8'd0, 1'b0, 1'b1);
    check("t6 op_count wrap", 32'(op_count), 32'd1);
    rsp_ready = 2'b00;
    set_req(0, 2'd0, 4'd2, 4'd2);
    wait_gnt(0);
    req[0] = 1'b0;
    set_req(1, 2'd3, 4'd3, 4'd1);
    cyc(2);
    req[1] = 1'b0;
    rsp_ready = 2'b11;
    cyc(1);
    for (int k = 0; k < 4; k++) begin
      cyc(1);
      check("t6 withdrawn gnt", 32'(gnt), 32'd0);
      check("t6 withdrawn rsp", 32'(rsp_valid), 32'd0);
    end
    check("t6 final op_count", 32'(op_count), 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
